// File: rtl/game_flow_pkg.sv
// Shared types and constants for the game flow sequencer.
//   state_e   : one-hot game state (also exported on state_o)
//   lives_t   : spare-lives counter, level_t: 1-based level, timer_t: frame timer
//   sat_inc() : saturating increment for the frame timer
package game_flow_pkg;

  typedef enum logic [6:0] {
    ST_IDLE        = 7'b0000001,
    ST_PLAY        = 7'b0000010,
    ST_HIT_FREEZE  = 7'b0000100,
    ST_HIT_WAIT    = 7'b0001000,
    ST_LEVEL_CLEAR = 7'b0010000,
    ST_GAME_OVER   = 7'b0100000,
    ST_GAME_WON    = 7'b1000000
  } state_e;

  localparam int LIVES_W         = 2;
  localparam int LEVEL_W         = 4;
  // Wide enough for both the hit freeze (<256) and the continue window (600).
  localparam int TIMER_W         = 10;
  localparam int CONTINUE_FRAMES = 600;

  typedef logic [LIVES_W-1:0] lives_t;
  typedef logic [LEVEL_W-1:0] level_t;
  typedef logic [TIMER_W-1:0] timer_t;

  // The frame timer holds at all-ones instead of wrapping, so flash_o and the
  // continue window never re-open on a long wait.
  function automatic timer_t sat_inc(input timer_t t);
    return (t == '1) ? t : t + timer_t'(1);
  endfunction

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector.
//   clk_i, reset_ni : clock, async active-low reset
//   d               : level input
//   rise            : high for the cycle where d is 1 and was 0 last cycle
// rst_val_p sets the history flop at reset; 1 means a level already high
// when reset releases is not treated as an edge.
module rise_edge_det #(
  parameter logic rst_val_p = 1'b0
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) d_q <= rst_val_p;
    else           d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: owns lives and level, walks
// title -> play -> hit/pause -> level-clear -> over/won.
// Ports:
//   clk_i, reset_ni        : clock, async active-low reset
//   start_i                : start/shoot button level
//   frame_i                : one-cycle pulse per video frame
//   hit_i, wave_clear_i    : collision events, honoured only in PLAY
//   run_o, freeze_o        : motion enables
//   flash_o                : player sprite blink during hit freeze/wait
//   player_rst_o, enemy_rst_o : one-cycle reload pulses
//   lives_o, level_o       : spare lives, 1-based level
//   game_over_o, game_won_o, state_o : status / one-hot debug state
//   cont_o                 : continue window open (GAME_FLOW_CTRL_CONTINUE_EN only)
// Build option: define GAME_FLOW_CTRL_CONTINUE_EN to allow continuing at the
// current level from GAME_OVER within CONTINUE_FRAMES frames.
module game_flow_ctrl
  import game_flow_pkg::*;
#(
  parameter int lives_init_p    = 2,
  parameter int lives_max_p     = 3,
  parameter int levels_p        = 8,
  parameter int freeze_frames_p = 90,
  parameter int flash_bit_p     = 3
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  input  logic         start_i,
  input  logic         frame_i,
  input  logic         hit_i,
  input  logic         wave_clear_i,
  output logic         run_o,
  output logic         freeze_o,
  output logic         flash_o,
  output logic         player_rst_o,
  output logic         enemy_rst_o,
  output logic [1:0]   lives_o,
  output logic [3:0]   level_o,
  output logic         game_over_o,
  output logic         game_won_o,
  output logic [6:0]   state_o
`ifdef GAME_FLOW_CTRL_CONTINUE_EN
  ,
  output logic         cont_o
`endif
);

  localparam lives_t LIVES_INIT    = lives_t'(lives_init_p);
  localparam lives_t LIVES_MAX     = lives_t'(lives_max_p);
  localparam level_t LEVEL_LAST    = level_t'(levels_p);
  localparam level_t LEVEL_FIRST   = level_t'(1);
  localparam timer_t FREEZE_FRAMES = timer_t'(freeze_frames_p);
`ifdef GAME_FLOW_CTRL_CONTINUE_EN
  localparam timer_t CONT_FRAMES   = timer_t'(CONTINUE_FRAMES);
`endif

  state_e state_q, state_d;
  lives_t lives_d;
  level_t level_d;
  timer_t timer_q, timer_d;
  logic   prst_d, erst_d;
  logic   start_rise;

  // History flop resets high: a button held through reset must not start a game.
  rise_edge_det #(.rst_val_p(1'b1)) u_start_edge (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .d        (start_i),
    .rise     (start_rise)
  );

  always_comb begin
    state_d = state_q;
    lives_d = lives_o;
    level_d = level_o;
    timer_d = timer_q;
    prst_d  = 1'b0;
    erst_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          state_d = ST_PLAY;
          lives_d = LIVES_INIT;
          level_d = LEVEL_FIRST;
          prst_d  = 1'b1;
          erst_d  = 1'b1;
        end
      end
      ST_PLAY: begin
        // hit has priority; a simultaneous wave clear is dropped
        if (hit_i) begin
          timer_d = '0;
          if (lives_o != '0) begin
            state_d = ST_HIT_FREEZE;
            lives_d = lives_o - lives_t'(1);
          end else begin
            state_d = ST_GAME_OVER;
          end
        end else if (wave_clear_i) begin
          if (level_o < LEVEL_LAST) begin
            state_d = ST_LEVEL_CLEAR;
            level_d = level_o + level_t'(1);
            // bonus life on reaching an even level
            if (!level_d[0] && (lives_o < LIVES_MAX))
              lives_d = lives_o + lives_t'(1);
          end else begin
            state_d = ST_GAME_WON;
          end
        end
      end
      ST_HIT_FREEZE: begin
        if (frame_i) begin
          timer_d = sat_inc(timer_q);
          if (timer_d >= FREEZE_FRAMES) state_d = ST_HIT_WAIT;
        end
      end
      ST_HIT_WAIT: begin
        // keep counting so the sprite keeps blinking while waiting
        if (frame_i) timer_d = sat_inc(timer_q);
        if (start_rise) begin
          state_d = ST_PLAY;
          prst_d  = 1'b1;
        end
      end
      ST_LEVEL_CLEAR: begin
        if (start_rise) begin
          state_d = ST_PLAY;
          prst_d  = 1'b1;
          erst_d  = 1'b1;
        end
      end
      ST_GAME_OVER: begin
        if (frame_i) timer_d = sat_inc(timer_q);
        if (start_rise) begin
`ifdef GAME_FLOW_CTRL_CONTINUE_EN
          // window judged on frames seen before this press
          if (timer_q < CONT_FRAMES) begin
            state_d = ST_PLAY;
            lives_d = LIVES_INIT;
            prst_d  = 1'b1;
            erst_d  = 1'b1;
          end else
`endif
          begin
            state_d = ST_IDLE;
            lives_d = LIVES_INIT;
            level_d = LEVEL_FIRST;
          end
        end
      end
      ST_GAME_WON: begin
        state_d = ST_GAME_WON;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they are flops
  // aligned with state_q.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= ST_IDLE;
      lives_o      <= LIVES_INIT;
      level_o      <= LEVEL_FIRST;
      timer_q      <= '0;
      run_o        <= 1'b0;
      freeze_o     <= 1'b0;
      flash_o      <= 1'b0;
      player_rst_o <= 1'b0;
      enemy_rst_o  <= 1'b0;
      game_over_o  <= 1'b0;
      game_won_o   <= 1'b0;
`ifdef GAME_FLOW_CTRL_CONTINUE_EN
      cont_o       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      lives_o      <= lives_d;
      level_o      <= level_d;
      timer_q      <= timer_d;
      run_o        <= (state_d == ST_PLAY);
      freeze_o     <= state_d inside {ST_HIT_FREEZE, ST_HIT_WAIT, ST_LEVEL_CLEAR};
      flash_o      <= (state_d inside {ST_HIT_FREEZE, ST_HIT_WAIT}) && timer_d[flash_bit_p];
      player_rst_o <= prst_d;
      enemy_rst_o  <= erst_d;
      game_over_o  <= (state_d == ST_GAME_OVER);
      game_won_o   <= (state_d == ST_GAME_WON);
`ifdef GAME_FLOW_CTRL_CONTINUE_EN
      cont_o       <= (state_d == ST_GAME_OVER) && (timer_d < CONT_FRAMES);
`endif
    end
  end

  assign state_o = state_q;

endmodule
